// File: rtl/io_pio_irq_ctrl_pkg.sv
// Shared definitions for the PIO edge/interrupt controller: register word indices and STATUS bit positions.
// Latency: n/a (constants and a decode helper only).
// Backpressure: n/a.
package io_pio_irq_ctrl_pkg;

  localparam logic [5:0] REG_LEVEL   = 6'd0;
  localparam logic [5:0] REG_PENDING = 6'd1;
  localparam logic [5:0] REG_MASK    = 6'd2;
  localparam logic [5:0] REG_RISE_EN = 6'd3;
  localparam logic [5:0] REG_FALL_EN = 6'd4;
  localparam logic [5:0] REG_STATUS  = 6'd5;

  localparam int STATUS_IRQ_BIT = 0;
  localparam int STATUS_DB_BIT  = 1;

  // True when a bus write targets the given word index.
  function automatic logic reg_wr(input logic we, input logic [5:0] word, input logic [5:0] idx);
    return we && (word == idx);
  endfunction

endpackage

// File: rtl/io_pio_debounce.sv
// Per-bit debouncer: a shared prescaler ticks every DB_DIV cycles; out follows in after 3 agreeing tick samples.
// Latency: 3*DB_DIV + 2 cycles worst case from a stable input to out.
// Backpressure: none; free-running, always accepts its input.
module io_pio_debounce #(
  parameter int WIDTH  = 8,
  parameter int DB_DIV = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  localparam int CW = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DB_DIV - 1);

  logic [CW-1:0]    cnt;
  logic             tick;
  logic [WIDTH-1:0] h0;
  logic [WIDTH-1:0] h1;
  logic [WIDTH-1:0] agree;

  assign tick  = (cnt == LAST);
  assign agree = ~(in ^ h0) & ~(in ^ h1);

  // Free-running prescaler, wraps at DB_DIV-1 and emits a single-cycle tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else if (tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end

  // On each tick shift the sample history; a bit only moves when the new sample matches both older ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h0  <= '0;
      h1  <= '0;
      out <= '0;
    end else if (tick) begin
      h1  <= h0;
      h0  <= in;
      out <= (agree & in) | (~agree & out);
    end
  end

endmodule

// File: rtl/io_pio_irq_ctrl.sv
// PIO edge-event/interrupt controller: sync (+optional debounce, macro IO_PIO_IRQ_DEBOUNCE_EN), edge latch, W1C pending, masked level irq.
// Latency: pio change -> PENDING on 3rd edge, irq on 4th (no debounce); register writes visible next cycle; reads zero latency.
// Backpressure: none; one single-cycle bus write per cycle, reads have no side effects.
module io_pio_irq_ctrl
  import io_pio_irq_ctrl_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DB_DIV = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       addr,
  input  logic             we,
  input  logic [31:0]      datain,
  output logic [31:0]      dataout,
  input  logic [WIDTH-1:0] pio,
  output logic             irq
);

  logic [5:0]       word;
  logic [WIDTH-1:0] wdat;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] flt;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] set_ev;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] rdv;
  logic             unused_bits;

  assign word        = addr[7:2];
  assign wdat        = datain[WIDTH-1:0];
  assign unused_bits = ^{addr[1:0], datain};

  // Two-flop synchronizer for the raw asynchronous inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pio;
      sync2 <= sync1;
    end
  end

`ifdef IO_PIO_IRQ_DEBOUNCE_EN
  localparam logic DB_PRESENT = 1'b1;

  io_pio_debounce #(
    .WIDTH  (WIDTH),
    .DB_DIV (DB_DIV)
  ) u_debounce (
    .clk   (clk),
    .reset (reset),
    .in    (sync2),
    .out   (flt)
  );
`else
  localparam logic DB_PRESENT = 1'b0;

  assign flt = sync2;
`endif

  // One-cycle delayed filtered level for edge detection; reset to 0 so inputs high at reset yield one rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= '0;
    else prev <= flt;
  end

  assign set_ev = (flt & ~prev & rise_en) | (~flt & prev & fall_en);
  assign clr    = reg_wr(we, word, REG_PENDING) ? wdat : '0;

  // Control registers; in PENDING a new event beats a same-cycle W1C clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      mask    <= '0;
      rise_en <= '0;
      fall_en <= '0;
    end else begin
      pending <= (pending & ~clr) | set_ev;
      if (reg_wr(we, word, REG_MASK))    mask    <= wdat;
      if (reg_wr(we, word, REG_RISE_EN)) rise_en <= wdat;
      if (reg_wr(we, word, REG_FALL_EN)) fall_en <= wdat;
    end
  end

  // Registered interrupt level from unmasked pending events.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else irq <= |(pending & mask);
  end

  // Read mux; unimplemented words and bits above WIDTH read as zero.
  always_comb begin
    rdv     = '0;
    dataout = '0;
    case (word)
      REG_LEVEL:   rdv = flt;
      REG_PENDING: rdv = pending;
      REG_MASK:    rdv = mask;
      REG_RISE_EN: rdv = rise_en;
      REG_FALL_EN: rdv = fall_en;
      default:     rdv = '0;
    endcase
    dataout[WIDTH-1:0] = rdv;
    if (word == REG_STATUS) begin
      dataout[STATUS_IRQ_BIT] = irq;
      dataout[STATUS_DB_BIT]  = DB_PRESENT;
    end
  end

endmodule

// File: tb/tb_io_pio_irq_ctrl.sv
// Self-checking bench for io_pio_irq_ctrl: directed scenarios plus randomized traffic against a queue-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_io_pio_irq_ctrl;
  import io_pio_irq_ctrl_pkg::*;

  localparam int WIDTH = 8;
`ifdef IO_PIO_IRQ_DEBOUNCE_EN
  localparam logic DBV = 1'b1;
`else
  localparam logic DBV = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       addr;
  logic             we;
  logic [31:0]      datain;
  logic [31:0]      dataout;
  logic [WIDTH-1:0] pio;
  logic             irq;

  int checks   = 0;
  int failures = 0;

  io_pio_irq_ctrl #(.WIDTH(WIDTH), .DB_DIV(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .we      (we),
    .datain  (datain),
    .dataout (dataout),
    .pio     (pio),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // Reference model: register contents plus a history of pio values seen at each clock edge.
  logic [WIDTH-1:0] m_pending, m_mask, m_rise, m_fall;
  logic             m_irq;
  logic [WIDTH-1:0] hist[$];

  function automatic logic [7:0] wa(input logic [5:0] w);
    return {w, 2'b00};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [5:0] w, input string tag, input logic [31:0] exp);
    we   = 1'b0;
    addr = wa(w);
    #1;
    check(tag, dataout, exp);
  endtask

  task automatic model_reset();
    m_pending = '0;
    m_mask    = '0;
    m_rise    = '0;
    m_fall    = '0;
    m_irq     = 1'b0;
    hist.delete();
    repeat (3) hist.push_back('0);
  endtask

  // Drive one bus cycle, advance the model by one edge, then wait until just after that edge.
  task automatic cyc(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [WIDTH-1:0] p);
    logic [WIDTH-1:0] lvl, prv, set, clr;
    logic             nirq;
    we = w; addr = a; datain = d; pio = p;
    lvl  = hist[0 + 1];
    prv  = hist[2];
    set  = (lvl & ~prv & m_rise) | (~lvl & prv & m_fall);
    nirq = |(m_pending & m_mask);
    clr  = (w && a[7:2] == REG_PENDING) ? d[WIDTH-1:0] : '0;
    m_pending = (m_pending & ~clr) | set;
    if (w && a[7:2] == REG_MASK)    m_mask = d[WIDTH-1:0];
    if (w && a[7:2] == REG_RISE_EN) m_rise = d[WIDTH-1:0];
    if (w && a[7:2] == REG_FALL_EN) m_fall = d[WIDTH-1:0];
    m_irq = nirq;
    hist.push_front(p);
    if (hist.size() > 4) void'(hist.pop_back());
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic check_all(input string tag);
    rd(REG_LEVEL,   {tag, ".level"},   32'(hist[1]));
    rd(REG_PENDING, {tag, ".pending"}, 32'(m_pending));
    rd(REG_MASK,    {tag, ".mask"},    32'(m_mask));
    rd(REG_RISE_EN, {tag, ".rise"},    32'(m_rise));
    rd(REG_FALL_EN, {tag, ".fall"},    32'(m_fall));
    rd(REG_STATUS,  {tag, ".status"},  {30'd0, DBV, m_irq});
    check({tag, ".irq"}, 32'(irq), 32'(m_irq));
  endtask

  initial begin
    logic [WIDTH-1:0] p;
    reset = 1'b1; we = 1'b0; addr = '0; datain = '0; pio = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state and register write/readback.
    check_all("reset");
    cyc(1'b1, wa(REG_MASK), 32'hFF, '0);
    cyc(1'b1, wa(REG_RISE_EN), 32'hFF, '0);
    rd(REG_MASK, "mask_ff", 32'hFF);
    rd(REG_RISE_EN, "rise_ff", 32'hFF);
    check_all("regs");

`ifdef IO_PIO_IRQ_DEBOUNCE_EN
    begin
      logic seen;
      int   first;
      cyc(1'b1, wa(REG_MASK), 32'h01, '0);
      cyc(1'b1, wa(REG_RISE_EN), 32'h01, '0);
      seen = 1'b0;
      for (int i = 0; i < 35; i++) begin
        cyc(1'b0, '0, '0, (i < 5) ? 8'h01 : 8'h00);
        rd(REG_LEVEL, "db_pulse_lvl", 32'h0);
        seen = seen | dataout[0];
      end
      check("db_pulse_seen", 32'(seen), 32'h0);
      rd(REG_PENDING, "db_pulse_pend", 32'h0);
      first = -1;
      for (int i = 1; i <= 20; i++) begin
        cyc(1'b0, '0, '0, 8'h01);
        addr = wa(REG_LEVEL);
        #1;
        if (first < 0 && dataout[0] === 1'b1) first = i;
      end
      check("db_hold_found", 32'(first > 0), 32'h1);
      check("db_hold_le14", 32'(first <= 14), 32'h1);
      rd(REG_LEVEL, "db_hold_lvl", 32'h01);
      rd(REG_PENDING, "db_hold_pend", 32'h01);
      check("db_hold_irq", 32'(irq), 32'h1);
    end
`else
    // Rising-edge capture on bit 0.
    cyc(1'b1, wa(REG_MASK), 32'h01, '0);
    cyc(1'b1, wa(REG_RISE_EN), 32'h01, '0);
    cyc(1'b0, '0, '0, 8'h01);
    rd(REG_PENDING, "rise_e1", 32'h0);
    cyc(1'b0, '0, '0, 8'h01);
    rd(REG_PENDING, "rise_e2", 32'h0);
    cyc(1'b0, '0, '0, 8'h01);
    rd(REG_PENDING, "rise_e3", 32'h01);
    check("rise_irq_e3", 32'(irq), 32'h0);
    cyc(1'b0, '0, '0, 8'h01);
    check("rise_irq_e4", 32'(irq), 32'h1);
    check_all("rise");
    repeat (4) cyc(1'b0, '0, '0, 8'h00);
    rd(REG_PENDING, "fall_ignored", 32'h01);

    // W1C clear, then a clear colliding with a new set.
    cyc(1'b1, wa(REG_PENDING), 32'h01, 8'h00);
    rd(REG_PENDING, "w1c_pend", 32'h0);
    check("w1c_irq_c1", 32'(irq), 32'h1);
    cyc(1'b0, '0, '0, 8'h00);
    check("w1c_irq_c2", 32'(irq), 32'h0);
    cyc(1'b0, '0, '0, 8'h01);
    cyc(1'b0, '0, '0, 8'h01);
    cyc(1'b1, wa(REG_PENDING), 32'h01, 8'h01);
    rd(REG_PENDING, "set_wins", 32'h01);
    check_all("w1c");

    // Falling edge on bit 7 while masked, then unmask.
    cyc(1'b1, wa(REG_MASK), 32'h00, 8'h01);
    cyc(1'b1, wa(REG_RISE_EN), 32'h00, 8'h01);
    cyc(1'b1, wa(REG_FALL_EN), 32'h80, 8'h01);
    cyc(1'b1, wa(REG_PENDING), 32'hFF, 8'h01);
    repeat (4) cyc(1'b0, '0, '0, 8'h81);
    rd(REG_PENDING, "fall_pre", 32'h0);
    repeat (3) cyc(1'b0, '0, '0, 8'h01);
    rd(REG_PENDING, "fall_pend", 32'h80);
    repeat (2) cyc(1'b0, '0, '0, 8'h01);
    check("fall_masked_irq", 32'(irq), 32'h0);
    cyc(1'b1, wa(REG_MASK), 32'h80, 8'h01);
    check("unmask_irq_c1", 32'(irq), 32'h0);
    cyc(1'b0, '0, '0, 8'h01);
    check("unmask_irq_c2", 32'(irq), 32'h1);
    check_all("fall");

    // Unused and read-only words ignore writes; unused words read zero.
    cyc(1'b1, wa(6'd9), 32'hFFFF_FFFF, 8'h01);
    cyc(1'b1, wa(REG_LEVEL), 32'hFFFF_FFFF, 8'h01);
    cyc(1'b1, wa(REG_STATUS), 32'hFFFF_FFFF, 8'h01);
    check_all("unused_wr");
    for (int w = 6; w < 64; w++) begin
      rd(6'(w), "unused_rd", 32'h0);
      if (w % 4 == 3) cyc(1'b0, '0, '0, 8'h01);
    end

    // Randomized traffic against the model.
    p = 8'h01;
    for (int i = 0; i < 300; i++) begin
      logic       w;
      logic [7:0] a;
      if ($urandom_range(0, 3) == 0) p[$urandom_range(0, WIDTH - 1)] ^= 1'b1;
      w = ($urandom_range(0, 2) == 0);
      a = {6'($urandom_range(0, 9)), 2'($urandom_range(0, 3))};
      cyc(w, a, $urandom, p);
      check_all("rand");
    end

    // Asynchronous reset mid-run with an input held high.
    reset = 1'b1;
    pio   = 8'h04;
    #1;
    check("arst_irq", 32'(irq), 32'h0);
    rd(REG_PENDING, "arst_pend", 32'h0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all("post_rst");
    cyc(1'b1, wa(REG_RISE_EN), 32'hFF, 8'h04);
    cyc(1'b0, '0, '0, 8'h04);
    rd(REG_PENDING, "rst_rise_e2", 32'h0);
    cyc(1'b0, '0, '0, 8'h04);
    rd(REG_PENDING, "rst_rise_e3", 32'h04);
    check_all("rst_rise");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_pio_irq_ctrl.md
# io_pio_irq_ctrl

Edge-event and interrupt controller for a bank of general-purpose parallel inputs (switches, buttons, external strobes). It sits on the CPU's word-addressed I/O bus beside the plain PIO input port. It synchronizes each input, optionally debounces it, and latches rising and falling edges into a write-1-to-clear pending register. A single level interrupt line is raised for the CPU when an unmasked event is pending.

## Interface
Parameters:
- WIDTH, 8, number of input bits; legal range 1..32.
- DB_DIV, 50000, debounce sample period in clk cycles; minimum 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- addr  input  8  byte address; only addr[7:2] is decoded.
- we  input  1  write strobe; one write per cycle when high.
- datain  input  32  write data.
- dataout  output  32  read data; combinational from addr and registered state.
- pio  input  WIDTH  raw asynchronous inputs.
- irq  output  1  registered interrupt request, level-sensitive.

## Operation
Register map by word index addr[7:2]. Bits above WIDTH read 0 and ignore writes.
- 0 LEVEL (RO): filtered level of each input.
- 1 PENDING (R/W1C): latched edge events; writing 1 clears the bit, writing 0 has no effect.
- 2 MASK (RW): interrupt enable per bit.
- 3 RISE_EN (RW): capture rising edges.
- 4 FALL_EN (RW): capture falling edges.
- 5 STATUS (RO): bit0 = irq, bit1 = debounce compiled in (1 when DEBOUNCE_EN is defined).
- 6..63: read 0, writes ignored.

Input pipeline:
- Each bit passes through a 2-flop synchronizer to give sync[i].
- The filtered level is flt[i]. It is sync[i] when debounce is absent, or the debouncer output otherwise.
- prev[i] holds flt[i] delayed one cycle.
- A rising edge is flt & ~prev; a falling edge is ~flt & prev.
- An edge sets PENDING[i] when the corresponding RISE_EN[i] or FALL_EN[i] bit is set.

Boundary rules:
- A set event and a W1C clear to the same bit in the same cycle: the set wins and the bit stays 1.
- Disabling RISE_EN or FALL_EN does not clear PENDING bits that are already set.
- Changing MASK affects irq on the next cycle only; PENDING is unchanged.
- Reset clears every register to 0: sync, prev, flt, PENDING, MASK, RISE_EN, FALL_EN, the debouncer state and irq.
- After reset, prev = 0. Any input that is high at reset produces one rising edge once the synchronizer fills. It is captured only if RISE_EN has been set by then.
- Reset asserted mid-operation abandons all state immediately. There is no partial-write hazard, because writes are single-cycle.

## Timing
- irq is a registered copy of |(PENDING & MASK), so it asserts 1 cycle after PENDING is set.
- Without debounce, a change on pio that is stable across an edge updates sync after 2 edges. PENDING is set on the 3rd edge and irq rises on the 4th.
- A register write is visible on dataout in the cycle after the write edge.
- A W1C clear drops irq 1 cycle after PENDING clears, unless another unmasked bit is still pending.
- A read has zero latency and no side effects; reading never clears PENDING.

## Configuration
Macro: IO_PIO_IRQ_DEBOUNCE_EN.

When the macro is defined:
- A shared free-running prescaler counts 0..DB_DIV-1 and emits a 1-cycle tick on wrap.
- On each tick, every bit shifts sync[i] into a 2-deep sample history.
- flt[i] takes the new sample when that sample equals both history entries, i.e. 3 consecutive agreeing ticks.
- A glitch shorter than 2 tick periods therefore never reaches flt.
- Worst-case latency from a stable input to flt is 3*DB_DIV + 2 cycles.

When the macro is not defined:
- There is no prescaler or history logic, and flt = sync.
- STATUS bit1 reads 0.

## Structure
- Shared I/O package holds the register word-index constants (REG_LEVEL .. REG_STATUS) and the STATUS bit positions.
- Natural sub-module: io_pio_debounce. It contains the prescaler plus per-bit history for WIDTH bits, with ports clk, reset, in, out. It is instantiated only under IO_PIO_IRQ_DEBOUNCE_EN.

## Test plan
Directed scenarios, built without debounce unless stated:
- Reset and registers: reset high, then release → all registers read 0 and irq = 0. Write 0xFF to MASK and RISE_EN → both read 0xFF (WIDTH = 8).
- Rising-edge capture: RISE_EN = 0x01, MASK = 0x01, pio[0] goes 0→1 → PENDING = 0x01 three edges later, irq = 1 on the next edge. A falling edge is not captured.
- W1C and simultaneous set: write 0x01 to PENDING → irq = 0 two cycles later. Write 0x01 to PENDING in the same cycle as a new edge on bit 0 → PENDING stays 0x01.
- Falling edge while masked: FALL_EN = 0x80, MASK = 0, pio[7] goes 1→0 → PENDING = 0x80 and irq stays 0. Then write MASK = 0x80 → irq = 1 one cycle later.
- Unused addresses: write 0xFFFFFFFF to word 9 → no register changes. Reads of words 6..63 return 0, and bits 31:8 of PENDING read 0.
- Debounce (IO_PIO_IRQ_DEBOUNCE_EN defined, DB_DIV = 4):
  - pio[0] pulses high for 5 cycles → LEVEL never changes and PENDING = 0.
  - pio[0] held high for 20 cycles → LEVEL[0] = 1 within 14 cycles and PENDING[0] = 1.
